// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NIBBLE_W   = 4;

  typedef struct packed {
    logic [NUM_DIGITS*NIBBLE_W-1:0] value;
    logic [NUM_DIGITS-1:0]          mask;
    logic                           lz;
  } frame_t;

  // A digit is dark when masked, or when it and every digit to its left is zero
  // under leading-zero suppression; the rightmost digit always shows.
  function automatic logic digit_dark(frame_t f, logic [1:0] idx);
    logic zero_run;
    zero_run = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx)) begin
        zero_run = zero_run & (f.value[i*NIBBLE_W +: NIBBLE_W] == '0);
      end
    end
    return f.mask[idx] | (f.lz & (idx != 2'd0) & zero_run);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler and digit index counter for the display scanner.
module scan_tick_gen #(
  parameter int DIVIDE_BY   = 17,
  parameter int DEAD_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [1:0] o_idx,
  output logic       o_slot_end,
  output logic       o_frame_end,
  output logic       o_in_dead
);

  localparam logic [DIVIDE_BY-1:0] DEAD_W = DIVIDE_BY'(DEAD_CYCLES);

  logic [DIVIDE_BY-1:0] r_cnt;
  logic [1:0]           r_idx;
  logic                 w_slot_end;

  assign w_slot_end = &r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_slot_end) r_idx <= r_idx + 1'b1;
    end
  end

  assign o_idx       = r_idx;
  assign o_slot_end  = w_slot_end;
  assign o_frame_end = w_slot_end && (r_idx == 2'd3);
  assign o_in_dead   = (r_cnt < DEAD_W);

endmodule

// File: rtl/display_scanner.sv
// Double-buffered 4-digit hex scanner for a common-anode display with
// leading-zero suppression, per-digit blanking and anti-ghosting dead time.
module display_scanner
  import display_pkg::*;
#(
  parameter int DIVIDE_BY   = 17,
  parameter int DEAD_CYCLES = 4
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_blank_mask,
  input  logic        i_lz_en,
  input  logic        i_load,
  output logic [3:0]  o_an,
  output logic [3:0]  o_digit,
  output logic        o_frame_start,
  output logic        o_pending
);

  logic [1:0] w_idx;
  logic       w_slot_end;
  logic       w_frame_end;
  logic       w_in_dead;
  logic       w_dark;

  frame_t     r_shadow;
  frame_t     r_active;
  logic       r_pending;
  logic [3:0] r_an;
  logic [3:0] r_digit;
  logic       r_frame_start;
  logic       r_origin;

  scan_tick_gen #(
    .DIVIDE_BY   (DIVIDE_BY),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_tick (
    .i_clk       (i_clock),
    .i_rst_n     (i_reset_n),
    .o_idx       (w_idx),
    .o_slot_end  (w_slot_end),
    .o_frame_end (w_frame_end),
    .o_in_dead   (w_in_dead)
  );

  assign w_dark = digit_dark(r_active, w_idx);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_shadow      <= '0;
      r_active      <= '{value: '0, mask: '1, lz: 1'b0};
      r_pending     <= 1'b0;
      r_an          <= 4'hF;
      r_digit       <= '0;
      r_frame_start <= 1'b0;
      r_origin      <= 1'b1;
    end else begin
      // Transfer reads the old shadow, so a load on the boundary waits a frame.
      if (w_frame_end && r_pending) r_active <= r_shadow;
      if (i_load) begin
        r_shadow  <= '{value: i_value, mask: i_blank_mask, lz: i_lz_en};
        r_pending <= 1'b1;
      end else if (w_frame_end) begin
        r_pending <= 1'b0;
      end
      r_an          <= (w_in_dead || w_dark) ? 4'hF : ~(4'b0001 << w_idx);
      r_digit       <= r_active.value[{w_idx, 2'b00} +: NIBBLE_W];
      // r_origin marks the cycle where cnt=0, idx=0 is being presented.
      r_origin      <= w_frame_end;
      r_frame_start <= r_origin;
    end
  end

  assign o_an          = r_an;
  assign o_digit       = r_digit;
  assign o_frame_start = r_frame_start;
  assign o_pending     = r_pending;

  logic w_unused;
  assign w_unused = w_slot_end;

endmodule
